// File: rtl/spi_command_decoder_pkg.sv
// Shared types and constants for the SPI command decoder slice.
// Imported by the interface, the response arbiter and the decoder top.
package spi_command_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPCODE  = 2'd1,
        OPERAND = 2'd2
    } state_t;

    localparam logic [7:0] IDLE_RESPONSE          = 8'h00;
    localparam int         DEFAULT_NUM_RESPONDERS = 4;

endpackage

// File: rtl/spi_command_decoder_if.sv
// Byte-level bus between the SPI shifter/subperipherals and the command decoder.
// The master side is the shifter plus responders; the slave side is the decoder.
interface spi_command_decoder_if
    import spi_command_pkg::*;
#(
    parameter int NUM_RESPONDERS      = DEFAULT_NUM_RESPONDERS,
    parameter int OPERAND_COUNT_WIDTH = 32
);
    logic                             cs_active_in;
    logic [7:0]                       rx_byte_in;
    logic                             rx_byte_valid_in;
    logic                             tx_byte_request_in;
    logic [NUM_RESPONDERS*8-1:0]      response_in;
    logic [NUM_RESPONDERS-1:0]        response_valid_in;
    logic [7:0]                       op_code_out;
    logic                             op_code_valid_out;
    logic [7:0]                       operand_out;
    logic                             operand_valid_out;
    logic [OPERAND_COUNT_WIDTH-1:0]   operand_count_out;
    logic [7:0]                       tx_byte_out;
    logic                             collision_out;

    modport master (
        output cs_active_in, rx_byte_in, rx_byte_valid_in, tx_byte_request_in,
               response_in, response_valid_in,
        input  op_code_out, op_code_valid_out, operand_out, operand_valid_out,
               operand_count_out, tx_byte_out, collision_out
    );

    modport slave (
        input  cs_active_in, rx_byte_in, rx_byte_valid_in, tx_byte_request_in,
               response_in, response_valid_in,
        output op_code_out, op_code_valid_out, operand_out, operand_valid_out,
               operand_count_out, tx_byte_out, collision_out
    );

endinterface

// File: rtl/spi_command_decoder_response_arbiter.sv
// Combinational fixed-priority response mux (lowest index wins) with a
// detector for more than one responder driving at once.
module response_arbiter
    import spi_command_pkg::*;
#(
    parameter int NUM_RESPONDERS = DEFAULT_NUM_RESPONDERS
) (
    input  logic [NUM_RESPONDERS*8-1:0] response_in,
    input  logic [NUM_RESPONDERS-1:0]   response_valid_in,
    output logic [7:0]                  response_byte,
    output logic                        multi_valid
);
    localparam logic [NUM_RESPONDERS-1:0] ONE = NUM_RESPONDERS'(1);

    always_comb begin
        response_byte = IDLE_RESPONSE;
        // Scan high to low so the lowest asserted index is the last writer.
        for (int i = NUM_RESPONDERS - 1; i >= 0; i--) begin
            if (response_valid_in[i]) begin
                response_byte = response_in[i*8 +: 8];
            end
        end
    end

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_valid = |(response_valid_in & (response_valid_in - ONE));

endmodule

// File: rtl/spi_command_decoder.sv
// Frames deserialized SPI bytes into op code / operand strobes and returns the
// arbitrated responder byte to the shifter. Single 72 MHz SPI clock domain.
module spi_command_decoder
    import spi_command_pkg::*;
#(
    parameter int NUM_RESPONDERS      = DEFAULT_NUM_RESPONDERS,
    parameter int OPERAND_COUNT_WIDTH = 32
) (
    input  logic                  clock_in,
    input  logic                  reset_in,
    spi_command_decoder_if.slave  bus
);
    typedef logic [OPERAND_COUNT_WIDTH-1:0] count_t;

    function automatic count_t sat_inc(input count_t v);
        return (&v) ? v : v + OPERAND_COUNT_WIDTH'(1);
    endfunction

    state_t     state_q;
    state_t     state_d;

    logic       capture_opcode;
    logic       capture_operand;
    logic       load_tx;
    logic       clear_txn;

    logic [7:0] arb_byte;
    logic       arb_multi;

    logic [7:0] op_code_p1;
    logic       op_code_vld_p1;
    logic [7:0] operand_p1;
    logic       operand_vld_p1;
    count_t     operand_count_p1;
    logic [7:0] tx_byte_p1;
    logic       collision_p1;

    response_arbiter #(
        .NUM_RESPONDERS (NUM_RESPONDERS)
    ) u_response_arbiter (
        .response_in       (bus.response_in),
        .response_valid_in (bus.response_valid_in),
        .response_byte     (arb_byte),
        .multi_valid       (arb_multi)
    );

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!bus.cs_active_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = OPCODE;
                OPCODE:  if (bus.rx_byte_valid_in) state_d = OPERAND;
                OPERAND: state_d = OPERAND;
                default: state_d = IDLE;
            endcase
        end
    end

    // A byte landing in the same cycle CS drops is discarded because clear_txn wins.
    always_comb begin
        clear_txn       = !bus.cs_active_in;
        capture_opcode  = bus.cs_active_in && (state_q == OPCODE)  && bus.rx_byte_valid_in;
        capture_operand = bus.cs_active_in && (state_q == OPERAND) && bus.rx_byte_valid_in;
        load_tx         = bus.cs_active_in && (state_q != IDLE)    && bus.tx_byte_request_in;
    end

    // ---- stage p1: registered transaction outputs ----
    always_ff @(posedge clock_in) begin
        if (reset_in || clear_txn) begin
            op_code_p1       <= '0;
            op_code_vld_p1   <= 1'b0;
            operand_p1       <= '0;
            operand_vld_p1   <= 1'b0;
            operand_count_p1 <= '0;
            tx_byte_p1       <= '0;
            collision_p1     <= 1'b0;
        end else begin
            operand_vld_p1 <= capture_operand;
            if (capture_opcode) begin
                op_code_p1       <= bus.rx_byte_in;
                op_code_vld_p1   <= 1'b1;
                operand_count_p1 <= '0;
            end else if (operand_vld_p1) begin
                // Count advances the cycle after each strobe so it names the strobed operand.
                operand_count_p1 <= sat_inc(operand_count_p1);
            end
            if (capture_operand) begin
                operand_p1 <= bus.rx_byte_in;
            end
            if (load_tx) begin
                tx_byte_p1 <= arb_byte;
            end
            if (arb_multi && op_code_vld_p1) begin
                collision_p1 <= 1'b1;
            end
        end
    end

    assign bus.op_code_out       = op_code_p1;
    assign bus.op_code_valid_out = op_code_vld_p1;
    assign bus.operand_out       = operand_p1;
    assign bus.operand_valid_out = operand_vld_p1;
    assign bus.operand_count_out = operand_count_p1;
    assign bus.tx_byte_out       = tx_byte_p1;
    assign bus.collision_out     = collision_p1;

endmodule

// File: tb/tb_spi_command_decoder.sv
// Scoreboard bench for spi_command_decoder: operand strobes are queued when
// driven and matched by a negedge monitor; framing/response outputs checked inline.
module tb_spi_command_decoder;
    import spi_command_pkg::*;

    logic clk;
    logic rst;

    spi_command_decoder_if #(.NUM_RESPONDERS(4), .OPERAND_COUNT_WIDTH(32)) bus ();

    spi_command_decoder #(
        .NUM_RESPONDERS      (4),
        .OPERAND_COUNT_WIDTH (32)
    ) dut (
        .clock_in (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #7 clk = ~clk;

    typedef struct packed {
        logic [7:0]  b;
        logic [31:0] idx;
    } op_exp_t;

    op_exp_t     sb_q[$];
    op_exp_t     mon_e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] next_idx = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit is_operand);
        bus.rx_byte_in       = b;
        bus.rx_byte_valid_in = 1'b1;
        if (is_operand) begin
            sb_q.push_back('{b: b, idx: next_idx});
            next_idx++;
        end else begin
            next_idx = '0;
        end
        tick();
        bus.rx_byte_valid_in = 1'b0;
    endtask

    task automatic tx_request();
        bus.tx_byte_request_in = 1'b1;
        tick();
        bus.tx_byte_request_in = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_op_code"},   bus.op_code_out,       '0);
        chk({tag, "_op_vld"},    bus.op_code_valid_out, '0);
        chk({tag, "_operand"},   bus.operand_out,       '0);
        chk({tag, "_opnd_vld"},  bus.operand_valid_out, '0);
        chk({tag, "_count"},     bus.operand_count_out, '0);
        chk({tag, "_tx"},        bus.tx_byte_out,       '0);
        chk({tag, "_collision"}, bus.collision_out,     '0);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.operand_valid_out) begin
            if (sb_q.size() == 0) begin
                chk("spurious_operand", bus.operand_valid_out, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("operand_byte",  bus.operand_out,       mon_e.b);
                chk("operand_count", bus.operand_count_out, mon_e.idx);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst                    = 1'b1;
        bus.cs_active_in       = 1'b0;
        bus.rx_byte_in         = '0;
        bus.rx_byte_valid_in   = 1'b0;
        bus.tx_byte_request_in = 1'b0;
        bus.response_in        = '0;
        bus.response_valid_in  = '0;
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;
        tick();

        // basic op code + two operands
        bus.cs_active_in = 1'b1;
        tick();
        send_byte(8'h20, 1'b0);
        @(negedge clk);
        chk("t1_op_code", bus.op_code_out,       8'h20);
        chk("t1_op_vld",  bus.op_code_valid_out, 1'b1);
        chk("t1_count0",  bus.operand_count_out, 32'd0);
        tick();
        send_byte(8'h01, 1'b1);
        tick();
        send_byte(8'h02, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk("t1_op_vld_hold", bus.op_code_valid_out, 1'b1);
        chk("t1_count_end",   bus.operand_count_out, 32'd2);
        bus.cs_active_in = 1'b0;
        tick();
        @(negedge clk);
        check_all_zero("t1_cs_low");
        tick();

        // single responder drives tx
        bus.cs_active_in = 1'b1;
        tick();
        send_byte(8'h31, 1'b0);
        bus.response_in[15:8]  = 8'hA5;
        bus.response_valid_in  = 4'b0010;
        tx_request();
        @(negedge clk);
        chk("t2_tx_a5", bus.tx_byte_out, 8'hA5);
        bus.response_in[15:8] = 8'h5A;
        tick();
        tick();
        @(negedge clk);
        chk("t2_tx_hold", bus.tx_byte_out, 8'hA5);
        bus.response_valid_in = '0;
        tx_request();
        @(negedge clk);
        chk("t2_tx_idle",   bus.tx_byte_out,   IDLE_RESPONSE);
        chk("t2_collision", bus.collision_out, 1'b0);
        bus.cs_active_in = 1'b0;
        tick();
        tick();

        // two responders: priority and sticky collision
        bus.cs_active_in = 1'b1;
        tick();
        send_byte(8'h32, 1'b0);
        bus.response_in       = '0;
        bus.response_in[7:0]  = 8'h11;
        bus.response_in[23:16]= 8'h22;
        bus.response_valid_in = 4'b0101;
        tx_request();
        @(negedge clk);
        chk("t3_tx_prio",   bus.tx_byte_out,   8'h11);
        chk("t3_collision", bus.collision_out, 1'b1);
        bus.response_valid_in = '0;
        tick();
        tick();
        @(negedge clk);
        chk("t3_collision_sticky", bus.collision_out, 1'b1);
        bus.cs_active_in = 1'b0;
        tick();
        @(negedge clk);
        chk("t3_collision_clr", bus.collision_out, 1'b0);
        chk("t3_tx_clr",        bus.tx_byte_out,   8'h00);
        tick();

        // back-to-back operands, then rx coincident with CS drop
        bus.cs_active_in = 1'b1;
        tick();
        send_byte(8'h50, 1'b0);
        send_byte(8'hA1, 1'b1);
        send_byte(8'hA2, 1'b1);
        send_byte(8'hA3, 1'b1);
        tick();
        tick();
        @(negedge clk);
        chk("t4_count_end", bus.operand_count_out, 32'd3);
        chk("t4_sb_empty",  sb_q.size(),           0);
        bus.rx_byte_in       = 8'h77;
        bus.rx_byte_valid_in = 1'b1;
        bus.cs_active_in     = 1'b0;
        tick();
        bus.rx_byte_valid_in = 1'b0;
        @(negedge clk);
        chk("t5_no_strobe", bus.operand_valid_out, 1'b0);
        check_all_zero("t5_cs_drop");
        tick();

        // reset mid-OPERAND with CS held
        bus.cs_active_in = 1'b1;
        tick();
        send_byte(8'h60, 1'b0);
        send_byte(8'h61, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("t6_reset");
        tick();
        send_byte(8'h40, 1'b0);
        @(negedge clk);
        chk("t6_op_code", bus.op_code_out,       8'h40);
        chk("t6_op_vld",  bus.op_code_valid_out, 1'b1);
        tick();
        send_byte(8'h41, 1'b1);
        tick();
        tick();
        bus.cs_active_in = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
